nes_pad_responder: RTL and testbench
====================================

Name: nes_pad_responder

Overview:
Device side of the NES gamepad serial protocol, the counterpart of the existing `controller` reader. It watches a host's latch and clock lines and answers with an 8-bit button snapshot on the serial data line. The snapshot comes from a `buttons` vector, either a CPU/AI player or a test stimulus. It lets one board emulate a pad toward another console or FPGA, and gives the `controller` reader a synthesizable loop-back partner. It runs in the pixel-clock (`clk_out`) domain of `top`.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on `latch_in` and `ctrl_clk_in` (minimum 2).
- FILL_BIT, 1'b1, `data_out` level driven after all 8 bits are sent (1 = released, matching an official pad).
- TURBO_DIV, 4, number of latch events per turbo phase (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- latch_in  input  1  host latch line; asynchronous to `clk`.
- ctrl_clk_in  input  1  host shift-clock line; asynchronous to `clk`.
- buttons  input  8  active-high pressed flags: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- data_out  output  1  serial data line, active-low (0 = pressed).
- busy  output  1  high from latch fall until the 8th bit has been shifted out.
- frame_done  output  1  one-cycle pulse when the 8th bit has been shifted out.
- bit_idx  output  4  index of the bit currently on `data_out` (0..8; 8 = fill).

Behaviour:
- Reset (on a `clk` edge with `rst` = 1):
  - state = IDLE, `data_out` = FILL_BIT, `busy` = 0, `frame_done` = 0, `bit_idx` = 8, shift register = 8'hFF.
  - Synchronizer flops reset to 0.
- Input synchronization:
  - `latch_in` and `ctrl_clk_in` each pass through SYNC_STAGES flops, then one edge-detect flop.
  - Edges are decided on the synchronized signals.
  - Input-to-action latency is SYNC_STAGES+1 cycles.
- States:
  - IDLE: `data_out` = FILL_BIT.
    - Synchronized latch high → LOAD.
  - LOAD (latch high): every cycle, shift register ← ~`buttons` (line is active-low).
    - `data_out` = ~`buttons`[0] (registered, so 1 cycle behind the load).
    - `bit_idx` = 0.
    - Clock rises while in LOAD are ignored.
    - Latch fall → SHIFT, `busy` = 1; the value loaded in the last latch-high cycle is frozen.
  - SHIFT: each synchronized `ctrl_clk` rising edge shifts the register right, filling FILL_BIT at the MSB.
    - `bit_idx` increments; `data_out` updates the next cycle.
    - On the edge that takes `bit_idx` from 7 to 8: `frame_done` pulses for 1 cycle, `busy` → 0, state → IDLE.
- Extra clock edges in IDLE: `data_out` stays at FILL_BIT and `bit_idx` saturates at 8.
- Latch rise during SHIFT: abort the frame with no `frame_done` pulse, go to LOAD, and reload.
- Latch rise and clock rise detected in the same cycle: latch wins.
- `buttons` changes during SHIFT do not affect the frame in flight.
- `data_out` is always driven from a flop (glitch-free).
- Host timing:
  - The host must hold latch high, and each clock phase, for at least SYNC_STAGES+2 `clk` cycles.
  - Shorter pulses are undefined and need not be detected.

Optional Feature:
- Macro NES_PAD_TURBO_EN.
- When defined:
  - Adds input `turbo_mask` [1:0] ([0]=A, [1]=B).
  - An internal counter counts latch rising edges modulo 2×TURBO_DIV.
  - For each masked button, the value loaded is `buttons`[i] AND (counter < TURBO_DIV), so a held button reads pressed for TURBO_DIV frames and released for TURBO_DIV frames.
  - The counter resets to 0 on `rst`.
- When undefined: no `turbo_mask` port and no counter; `buttons` are loaded as-is.

Test Plan:
- Reset: hold `rst` 3 cycles → `data_out` = 1, `busy` = 0, `bit_idx` = 8, `frame_done` = 0.
- Basic frame: `buttons` = 8'b0000_0101 (A, Select), latch pulse of 12 cycles, then 8 clock pulses of 12 cycles each → sampled `data_out` sequence 0,1,0,1,1,1,1,1; then FILL_BIT = 1; exactly one `frame_done` pulse.
- Loop-back: connect to the `controller` reader with `buttons` = 8'hA5 → the reader's `buttons` output equals 8'hA5 after one poll.
- Snapshot freeze: change `buttons` from 8'hFF to 8'h00 after the latch falls → the remaining bits still read 0 (pressed).
- Abort: re-raise latch after 3 clock pulses → no `frame_done`, `bit_idx` back to 0, new frame starts from A.
- Turbo (NES_PAD_TURBO_EN, TURBO_DIV = 4): `turbo_mask` = 2'b01 with A held → A reads pressed on frames 0-3, released on 4-7, pressed on 8-11; B unaffected.

Source files
------------

// File: rtl/nes_pad_responder.sv
// +----------------------------------------------------------------------------+
// | nes_pad_responder: device side of the NES pad serial protocol (opt. macro  |
// | NES_PAD_TURBO_EN adds turbo_mask). Rev 1.0                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module nes_pad_responder #(
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_BIT    = 1'b1,
  parameter int   TURBO_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       latch_in,
  input  logic       ctrl_clk_in,
  input  logic [7:0] buttons,
`ifdef NES_PAD_TURBO_EN
  input  logic [1:0] turbo_mask,
`endif
  output logic       data_out,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] bit_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] ctrl_sync_q, ctrl_sync_d;
  logic                   latch_prev_q, latch_prev_d;
  logic                   ctrl_prev_q, ctrl_prev_d;

  logic [7:0] shreg_q, shreg_d;
  logic [3:0] bit_idx_q, bit_idx_d;
  logic       data_out_q, data_out_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;

  logic       latch_s, ctrl_s;
  logic       latch_rise, ctrl_rise;
  logic [7:0] load_val;

  // Edges are taken on the synchronized copies only, never on the raw pins.
  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], latch_in};
    ctrl_sync_d  = {ctrl_sync_q[SYNC_STAGES-2:0], ctrl_clk_in};
    latch_s      = latch_sync_q[SYNC_STAGES-1];
    ctrl_s       = ctrl_sync_q[SYNC_STAGES-1];
    latch_prev_d = latch_s;
    ctrl_prev_d  = ctrl_s;
    latch_rise   = latch_s & ~latch_prev_q;
    ctrl_rise    = ctrl_s & ~ctrl_prev_q;
  end

`ifdef NES_PAD_TURBO_EN
  localparam int               CNT_W    = $clog2(2 * TURBO_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * TURBO_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TURBO_DIV);

  logic [CNT_W-1:0] turbo_cnt_q, turbo_cnt_d;
  logic             turbo_on_q, turbo_on_d;
  logic             turbo_on;

  // The phase is decided on the latch rise and held for the whole latch window,
  // so every reload within one frame sees the same turbo phase.
  always_comb begin
    turbo_cnt_d = turbo_cnt_q;
    turbo_on_d  = turbo_on_q;
    turbo_on    = turbo_on_q;
    if (latch_rise) begin
      turbo_on    = (turbo_cnt_q < CNT_HALF);
      turbo_on_d  = turbo_on;
      turbo_cnt_d = (turbo_cnt_q == CNT_LAST) ? '0 : turbo_cnt_q + CNT_W'(1);
    end
    load_val    = buttons;
    load_val[0] = buttons[0] & (~turbo_mask[0] | turbo_on);
    load_val[1] = buttons[1] & (~turbo_mask[1] | turbo_on);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      turbo_cnt_q <= '0;
      turbo_on_q  <= 1'b1;
    end else begin
      turbo_cnt_q <= turbo_cnt_d;
      turbo_on_q  <= turbo_on_d;
    end
  end
`else
  assign load_val = buttons;
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    data_out_d   = shreg_q[0];
    case (state_q)
      ST_IDLE: begin
        data_out_d = FILL_BIT;
        bit_idx_d  = 4'd8;
        busy_d     = 1'b0;
        if (latch_s) begin
          state_d   = ST_LOAD;
          shreg_d   = ~load_val;
          bit_idx_d = 4'd0;
        end
      end
      ST_LOAD: begin
        bit_idx_d = 4'd0;
        busy_d    = 1'b0;
        if (latch_s) begin
          shreg_d = ~load_val;
        end else begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        // A new latch aborts the frame and takes priority over a coincident clock.
        if (latch_rise) begin
          state_d   = ST_LOAD;
          shreg_d   = ~load_val;
          bit_idx_d = 4'd0;
          busy_d    = 1'b0;
        end else if (ctrl_rise) begin
          shreg_d   = {FILL_BIT, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd7) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      latch_sync_q <= '0;
      ctrl_sync_q  <= '0;
      latch_prev_q <= 1'b0;
      ctrl_prev_q  <= 1'b0;
      shreg_q      <= 8'hFF;
      bit_idx_q    <= 4'd8;
      data_out_q   <= FILL_BIT;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      latch_sync_q <= latch_sync_d;
      ctrl_sync_q  <= ctrl_sync_d;
      latch_prev_q <= latch_prev_d;
      ctrl_prev_q  <= ctrl_prev_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign bit_idx    = bit_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_responder.sv
// +----------------------------------------------------------------------------+
// | tb_nes_pad_responder: directed frames against hand-computed line patterns. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_nes_pad_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       latch_in;
  logic       ctrl_clk_in;
  logic [7:0] buttons;
  logic       data_out;
  logic       busy;
  logic       frame_done;
  logic [3:0] bit_idx;

  int n_total = 0;
  int n_pass  = 0;
  int fd_cnt  = 0;

  nes_pad_responder #(
    .SYNC_STAGES(2),
    .FILL_BIT   (1'b1),
    .TURBO_DIV  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .latch_in   (latch_in),
    .ctrl_clk_in(ctrl_clk_in),
    .buttons    (buttons),
    .data_out   (data_out),
    .busy       (busy),
    .frame_done (frame_done),
    .bit_idx    (bit_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
  end

  typedef struct {
    logic [7:0] btn;
    logic [7:0] line;  // expected data_out level for bit i
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clk_pulse();
    ctrl_clk_in = 1'b1;
    tick(12);
    ctrl_clk_in = 1'b0;
    tick(12);
  endtask

  task automatic do_latch(input logic [7:0] btn, input logic [7:0] line);
    buttons  = btn;
    latch_in = 1'b1;
    tick(12);
    check("load_idx", {4'd0, bit_idx}, 8'd0);
    check("load_busy", {7'd0, busy}, 8'd0);
    check("load_data", {7'd0, data_out}, {7'd0, line[0]});
    latch_in = 1'b0;
    tick(12);
    check("shift_busy", {7'd0, busy}, 8'd1);
  endtask

  task automatic shift_bits(input logic [7:0] line, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("bit%0d_data", i), {7'd0, data_out}, {7'd0, line[i]});
      check($sformatf("bit%0d_idx", i), {4'd0, bit_idx}, 8'(i));
      clk_pulse();
    end
  endtask

  task automatic check_end(input int fd_before);
    check("fill_data", {7'd0, data_out}, 8'd1);
    check("fill_idx", {4'd0, bit_idx}, 8'd8);
    check("end_busy", {7'd0, busy}, 8'd0);
    check("frame_done_cnt", 8'(fd_cnt - fd_before), 8'd1);
  endtask

  initial begin
    int fd0;
    vecs[0] = '{btn: 8'h05, line: 8'hFA};
    vecs[1] = '{btn: 8'hA5, line: 8'h5A};
    vecs[2] = '{btn: 8'h00, line: 8'hFF};
    vecs[3] = '{btn: 8'hFF, line: 8'h00};
    vecs[4] = '{btn: 8'h80, line: 8'h7F};
    vecs[5] = '{btn: 8'h3C, line: 8'hC3};

    rst         = 1'b1;
    latch_in    = 1'b0;
    ctrl_clk_in = 1'b0;
    buttons     = 8'h00;
    tick(3);
    check("rst_data", {7'd0, data_out}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_idx", {4'd0, bit_idx}, 8'd8);
    check("rst_fd", {7'd0, frame_done}, 8'd0);
    rst = 1'b0;
    tick(4);

    for (int v = 0; v < 6; v++) begin
      fd0 = fd_cnt;
      do_latch(vecs[v].btn, vecs[v].line);
      shift_bits(vecs[v].line, 8);
      check_end(fd0);
    end

    // Clocks with no latch leave the line released and the index saturated.
    fd0 = fd_cnt;
    clk_pulse();
    clk_pulse();
    clk_pulse();
    check("idle_data", {7'd0, data_out}, 8'd1);
    check("idle_idx", {4'd0, bit_idx}, 8'd8);
    check("idle_fd", 8'(fd_cnt - fd0), 8'd0);

    // Snapshot is frozen once the latch falls.
    fd0 = fd_cnt;
    do_latch(8'hFF, 8'h00);
    buttons = 8'h00;
    shift_bits(8'h00, 8);
    check_end(fd0);

    // Re-latch after three bits aborts without a frame_done pulse.
    fd0 = fd_cnt;
    do_latch(8'h05, 8'hFA);
    shift_bits(8'hFA, 3);
    check("abort_idx_before", {4'd0, bit_idx}, 8'd3);
    do_latch(8'hFA, 8'h05);
    check("abort_no_fd", 8'(fd_cnt - fd0), 8'd0);
    shift_bits(8'h05, 8);
    check_end(fd0);

    // Latch and clock rising together: latch wins, no shift happens.
    fd0 = fd_cnt;
    do_latch(8'h3C, 8'hC3);
    shift_bits(8'hC3, 2);
    buttons     = 8'h81;
    latch_in    = 1'b1;
    ctrl_clk_in = 1'b1;
    tick(12);
    check("tie_idx", {4'd0, bit_idx}, 8'd0);
    check("tie_data", {7'd0, data_out}, 8'd0);
    check("tie_no_fd", 8'(fd_cnt - fd0), 8'd0);
    latch_in = 1'b0;
    tick(12);
    ctrl_clk_in = 1'b0;
    tick(12);
    shift_bits(8'h7E, 8);
    check_end(fd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
